// File: rtl/fwd_pkg.sv
// Shared types and select-code encoding for the forwarding / load-use hazard unit.
package fwd_pkg;

  localparam int unsigned SB_RW_W     = 8;
  localparam int unsigned SEL_SPECIAL = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RW_W-1:0] rw;
    logic               load;
  } sb_entry_t;

  function automatic int unsigned sel_regfile(input int unsigned depth);
    return depth + 1;
  endfunction

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority encoder: youngest valid scoreboard entry whose destination equals src.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SW     = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [REG_AW-1:0]     src,
  output logic                  hit_c,
  output logic [SW-1:0]         k_c,
  output logic                  load_c
);

  // Scan oldest to youngest so the lowest position is the last one assigned.
  always_comb begin
    hit_c  = 1'b0;
    k_c    = '0;
    load_c = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if ((src != '0) && entries[i].valid && (entries[i].rw == SB_RW_W'(src))) begin
        hit_c  = 1'b1;
        k_c    = SW'(i + 1);
        load_c = entries[i].load;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID/EX forwarding select and load-use stall generator with a DEPTH-deep producer scoreboard.
// FWD_STORE_DATA_EN adds a forwarded store-data select instead of stalling stores on any hit.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int unsigned DEPTH    = 2,
  parameter  int unsigned REG_AW   = 5,
  parameter  int unsigned LOAD_LAT = 2,
  localparam int unsigned SW       = sel_width(DEPTH)
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              ID_Valid,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [REG_AW-1:0] ID_Rw,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              UseShamt,
  input  logic              UseImmed,
  input  logic              Flush,
  output logic              Stall,
  output logic              EX_Valid,
  output logic [SW-1:0]     AluOpCtrlA,
  output logic [SW-1:0]     AluOpCtrlB
`ifdef FWD_STORE_DATA_EN
  ,
  output logic [SW-1:0]     StoreDataCtrl
`endif
);

  localparam logic [SW-1:0] SEL_RF = SW'(sel_regfile(DEPTH));
  localparam logic [SW-1:0] SEL_SP = SW'(SEL_SPECIAL);
  localparam logic [SW-1:0] LAT    = SW'(LOAD_LAT);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [SW-1:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;

  logic          a_hit, a_load, b_hit, b_load;
  logic [SW-1:0] a_k, b_k;
  logic          stall_a, stall_b, stall_s;
  logic          accept;

  fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SW(SW)) u_match_rs (
    .entries(sb_q), .src(ID_Rs), .hit_c(a_hit), .k_c(a_k), .load_c(a_load)
  );

  fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SW(SW)) u_match_rt (
    .entries(sb_q), .src(ID_Rt), .hit_c(b_hit), .k_c(b_k), .load_c(b_load)
  );

  assign stall_a = !UseShamt && a_hit && a_load && (a_k < LAT);
  assign stall_b = !UseImmed && b_hit && b_load && (b_k < LAT);

`ifdef FWD_STORE_DATA_EN
  logic          s_hit, s_load;
  logic [SW-1:0] s_k;
  logic [SW-1:0] sd_q, sd_d;

  fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SW(SW)) u_match_sd (
    .entries(sb_q), .src(ID_Rt), .hit_c(s_hit), .k_c(s_k), .load_c(s_load)
  );

  assign stall_s = ID_MemWrite && s_hit && s_load && (s_k < LAT);
`else
  // Without store-data forwarding the store must wait until its producer retires.
  assign stall_s = ID_MemWrite && b_hit;
`endif

  assign Stall  = ID_Valid && !Flush && (stall_a || stall_b || stall_s);
  assign accept = ID_Valid && !Stall && !Flush;

  // Scoreboard shift; a stalled or invalid ID slot enters as a bubble.
  always_comb begin
    sb_d = '0;
    if (!Flush) begin
      if (accept) begin
        sb_d[0].valid = ID_RegWrite && (ID_Rw != '0);
        sb_d[0].rw    = SB_RW_W'(ID_Rw);
        sb_d[0].load  = ID_MemRead;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        sb_d[i] = sb_q[i-1];
      end
    end
  end

  always_comb begin
    ex_valid_d = 1'b0;
    alu_a_d    = SEL_RF;
    alu_b_d    = SEL_RF;
    if (accept) begin
      ex_valid_d = 1'b1;
      alu_a_d    = UseShamt ? SEL_SP : (a_hit ? a_k : SEL_RF);
      alu_b_d    = UseImmed ? SEL_SP : (b_hit ? b_k : SEL_RF);
    end
  end

`ifdef FWD_STORE_DATA_EN
  always_comb begin
    sd_d = SEL_RF;
    if (accept && ID_MemWrite && s_hit) begin
      sd_d = s_k;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      sd_q <= SEL_RF;
    end else begin
      sd_q <= sd_d;
    end
  end

  assign StoreDataCtrl = sd_q;
`endif

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      sb_q       <= '0;
      ex_valid_q <= 1'b0;
      alu_a_q    <= SEL_RF;
      alu_b_q    <= SEL_RF;
    end else begin
      sb_q       <= sb_d;
      ex_valid_q <= ex_valid_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
    end
  end

  assign EX_Valid   = ex_valid_q;
  assign AluOpCtrlA = alu_a_q;
  assign AluOpCtrlB = alu_b_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Vector-table bench for fwd_hazard_unit (DEPTH=2, LOAD_LAT=2); registered results go through a queue.
module tb_fwd_hazard_unit;

  logic       CLK = 1'b0;
  logic       Reset_L;
  logic       ID_Valid, ID_RegWrite, ID_MemRead, ID_MemWrite, UseShamt, UseImmed, Flush;
  logic [4:0] ID_Rs, ID_Rt, ID_Rw;
  logic       Stall, EX_Valid;
  logic [1:0] AluOpCtrlA, AluOpCtrlB;
`ifdef FWD_STORE_DATA_EN
  logic [1:0] StoreDataCtrl;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fwd_hazard_unit #(.DEPTH(2), .REG_AW(5), .LOAD_LAT(2)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .ID_Valid(ID_Valid),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rw(ID_Rw),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .UseShamt(UseShamt), .UseImmed(UseImmed), .Flush(Flush),
    .Stall(Stall), .EX_Valid(EX_Valid), .AluOpCtrlA(AluOpCtrlA), .AluOpCtrlB(AluOpCtrlB)
`ifdef FWD_STORE_DATA_EN
    , .StoreDataCtrl(StoreDataCtrl)
`endif
  );

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs, rt, rw;
    logic       we, mr, mw, ush, uim, fl;
    logic       e_stall, e_exv;
    logic [1:0] e_a, e_b, e_sd;
  } vec_t;

  typedef struct {
    string      name;
    logic       exv;
    logic [1:0] a, b, sd;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input string name, input logic v, input logic [4:0] rs, rt, rw,
                              input logic we, mr, mw, ush, uim, fl,
                              input logic e_stall, e_exv, input logic [1:0] e_a, e_b, e_sd);
    vec_t t;
    t.name = name; t.v = v; t.rs = rs; t.rt = rt; t.rw = rw;
    t.we = we; t.mr = mr; t.mw = mw; t.ush = ush; t.uim = uim; t.fl = fl;
    t.e_stall = e_stall; t.e_exv = e_exv; t.e_a = e_a; t.e_b = e_b; t.e_sd = e_sd;
    return t;
  endfunction

  function automatic vec_t idle();
    return mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 3);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ID_Valid = t.v; ID_Rs = t.rs; ID_Rt = t.rt; ID_Rw = t.rw;
    ID_RegWrite = t.we; ID_MemRead = t.mr; ID_MemWrite = t.mw;
    UseShamt = t.ush; UseImmed = t.uim; Flush = t.fl;
  endtask

  // Drive one ID slot, check Stall in-cycle, then check the registered EX view one edge later.
  task automatic apply(input vec_t t);
    exp_t e;
    drive(t);
    #1;
    chk({t.name, ".stall"}, 8'(Stall), 8'(t.e_stall));
    exp_q.push_back('{t.name, t.e_exv, t.e_a, t.e_b, t.e_sd});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk({e.name, ".exv"}, 8'(EX_Valid), 8'(e.exv));
    chk({e.name, ".selA"}, 8'(AluOpCtrlA), 8'(e.a));
    chk({e.name, ".selB"}, 8'(AluOpCtrlB), 8'(e.b));
`ifdef FWD_STORE_DATA_EN
    chk({e.name, ".sd"}, 8'(StoreDataCtrl), 8'(e.sd));
`endif
  endtask

  initial begin
    Reset_L = 1'b0;
    drive(idle());
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.stall", 8'(Stall), 8'd0);
    chk("reset.exv", 8'(EX_Valid), 8'd0);
    chk("reset.selA", 8'(AluOpCtrlA), 8'd3);
    chk("reset.selB", 8'(AluOpCtrlB), 8'd3);
    Reset_L = 1'b1;
    @(posedge CLK);
    #1;

    //                name       v  rs  rt  rw we mr mw sh im fl  st ex  a  b sd
    vecs.push_back(idle());
    vecs.push_back(mk("add_r3",  1,  1,  2,  3, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("use_k1",  1,  3,  5,  4, 1, 0, 0, 0, 0, 0,  0, 1, 1, 3, 3));
    vecs.push_back(idle()); vecs.push_back(idle());
    vecs.push_back(mk("add_r3",  1,  1,  2,  3, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("add_r7",  1,  8,  9,  7, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("use_k2",  1,  3,  5,  4, 1, 0, 0, 0, 0, 0,  0, 1, 2, 3, 3));
    vecs.push_back(idle()); vecs.push_back(idle());
    vecs.push_back(mk("add_r3",  1,  1,  2,  3, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("add_r7",  1, 10, 11,  7, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("add_r8",  1, 10, 11,  8, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("use_k3",  1,  3,  5,  4, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(idle()); vecs.push_back(idle());
    vecs.push_back(mk("lw_r3",   1,  1,  3,  3, 1, 1, 0, 0, 1, 0,  0, 1, 3, 0, 3));
    vecs.push_back(mk("lu_stl",  1,  3,  3,  4, 1, 0, 0, 0, 0, 0,  1, 0, 3, 3, 3));
    vecs.push_back(mk("lu_go",   1,  3,  3,  4, 1, 0, 0, 0, 0, 0,  0, 1, 2, 2, 3));
    vecs.push_back(idle()); vecs.push_back(idle());
    vecs.push_back(mk("lw_r3",   1,  1,  3,  3, 1, 1, 0, 0, 1, 0,  0, 1, 3, 0, 3));
    vecs.push_back(mk("gap",     1, 10, 11,  7, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("lu_k2",   1,  3,  7,  4, 1, 0, 0, 0, 0, 0,  0, 1, 2, 1, 3));
    vecs.push_back(idle()); vecs.push_back(idle());
    vecs.push_back(mk("wr_r0",   1,  1,  2,  0, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("rd_r0",   1,  0,  0,  5, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(idle()); vecs.push_back(idle());
    vecs.push_back(mk("add_r6",  1,  1,  2,  6, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk("immed",   1,  1,  6,  9, 1, 0, 0, 0, 1, 0,  0, 1, 3, 0, 3));
    vecs.push_back(mk("shamt",   1,  6,  6, 10, 1, 0, 0, 1, 0, 0,  0, 1, 0, 2, 3));
    vecs.push_back(idle()); vecs.push_back(idle());
    vecs.push_back(mk("lw_r3",   1,  1,  3,  3, 1, 1, 0, 0, 1, 0,  0, 1, 3, 0, 3));
    vecs.push_back(mk("stl_fl",  1,  3,  3,  4, 1, 0, 0, 0, 0, 1,  0, 0, 3, 3, 3));
    vecs.push_back(mk("post_fl", 1,  3,  3,  4, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
    vecs.push_back(idle()); vecs.push_back(idle());
    vecs.push_back(mk("add_r3",  1,  1,  2,  3, 1, 0, 0, 0, 0, 0,  0, 1, 3, 3, 3));
`ifdef FWD_STORE_DATA_EN
    vecs.push_back(mk("sw_fwd",  1,  1,  3,  0, 0, 0, 1, 0, 1, 0,  0, 1, 3, 0, 1));
`else
    vecs.push_back(mk("sw_stl1", 1,  1,  3,  0, 0, 0, 1, 0, 1, 0,  1, 0, 3, 3, 3));
    vecs.push_back(mk("sw_stl2", 1,  1,  3,  0, 0, 0, 1, 0, 1, 0,  1, 0, 3, 3, 3));
    vecs.push_back(mk("sw_go",   1,  1,  3,  0, 0, 0, 1, 0, 1, 0,  0, 1, 3, 0, 3));
`endif
    vecs.push_back(idle()); vecs.push_back(idle());

    foreach (vecs[i]) apply(vecs[i]);

    // Reset pulse in the middle of a load-use stall.
    apply(mk("lw_r3", 1, 1, 3, 3, 1, 1, 0, 0, 1, 0, 0, 1, 3, 0, 3));
    drive(mk("lu", 1, 3, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3, 3));
    #1;
    chk("midrst.pre_stall", 8'(Stall), 8'd1);
    Reset_L = 1'b0;
    #1;
    chk("midrst.stall", 8'(Stall), 8'd0);
    chk("midrst.exv", 8'(EX_Valid), 8'd0);
    chk("midrst.selA", 8'(AluOpCtrlA), 8'd3);
    chk("midrst.selB", 8'(AluOpCtrlB), 8'd3);
    @(posedge CLK);
    #1;
    Reset_L = 1'b1;
    apply(mk("post_rst", 1, 3, 3, 4, 1, 0, 0, 0, 0, 0, 0, 1, 3, 3, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
